matrix_entry_ctrl: RTL and testbench

Front-end initiator for the 8×8 determinant solver. It collects 64 four-bit matrix entries one at a time from the board inputs and assembles them into the 256-bit flat matrix bus. It issues the Start handshake to the solver, waits for the solver's done state, captures the 32-bit determinant and returns Ack. It holds the result for display until the user clears or re-runs.

---
 rtl/matrix_entry_ctrl_if.sv | 47 ++++
 rtl/matrix_entry_ctrl.sv | 146 ++++++++++++++
 tb/tb_matrix_entry_ctrl.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/matrix_entry_ctrl_if.sv
// Purpose : board/solver-facing bundle of the 8x8 determinant front end.
// Latency : n/a (wires only).
// Backpressure: none; Start/Ack form a level handshake with the solver.
// Ports   : pulses and Entry_Val from the board, Solver_* / Det_In from the
//           solver, matrix bus, Start/Ack, result and one-hot state outputs.
interface matrix_entry_ctrl_if #(
   parameter int N_ENTRIES = 64,
   parameter int ENTRY_W   = 4
);
   logic [ENTRY_W-1:0]           Entry_Val;
   logic                         Enter_Pulse;
   logic                         Back_Pulse;
   logic                         Go_Pulse;
   logic                         Clear_Pulse;
   logic                         Solver_Enter;
   logic                         Solver_Done;
   logic [31:0]                  Det_In;
   logic [N_ENTRIES*ENTRY_W-1:0] Matrix_Flat;
   logic                         Start;
   logic                         Ack;
   logic [31:0]                  Det_Out;
   logic                         Result_Valid;
   logic [6:0]                   Entry_Count;
   logic                         q_Clear;
   logic                         q_Fill;
   logic                         q_Ready;
   logic                         q_Issue;
   logic                         q_Wait;
   logic                         q_Ack;
   logic                         q_Result;

   // Controller side.
   modport master (
      input  Entry_Val, Enter_Pulse, Back_Pulse, Go_Pulse, Clear_Pulse,
             Solver_Enter, Solver_Done, Det_In,
      output Matrix_Flat, Start, Ack, Det_Out, Result_Valid, Entry_Count,
             q_Clear, q_Fill, q_Ready, q_Issue, q_Wait, q_Ack, q_Result
   );

   // Board/solver side.
   modport slave (
      output Entry_Val, Enter_Pulse, Back_Pulse, Go_Pulse, Clear_Pulse,
             Solver_Enter, Solver_Done, Det_In,
      input  Matrix_Flat, Start, Ack, Det_Out, Result_Valid, Entry_Count,
             q_Clear, q_Fill, q_Ready, q_Issue, q_Wait, q_Ack, q_Result
   );
endinterface

// File: rtl/matrix_entry_ctrl.sv
// Purpose : collects 64 x 4-bit entries into a flat matrix bus, runs the
//           Start/Done/Ack handshake with the solver, holds the determinant.
// Latency : entry write 1 cycle; Go->Start 1 cycle min; Done->Ack 1 cycle.
// Backpressure: ISSUE waits indefinitely for Solver_Enter, WAIT for Solver_Done.
// Ports   : Clk, Reset (sync, active-low), bus (matrix_entry_ctrl_if.master).
module matrix_entry_ctrl (
   input  logic                 Clk,
   input  logic                 Reset,
   matrix_entry_ctrl_if.master  bus
);
   localparam int N_ENTRIES = 64;
   localparam int ENTRY_W   = 4;
   localparam int FLAT_W    = N_ENTRIES * ENTRY_W;

   typedef enum logic [6:0] {
      S_CLEAR  = 7'b000_0001,
      S_FILL   = 7'b000_0010,
      S_READY  = 7'b000_0100,
      S_ISSUE  = 7'b000_1000,
      S_WAIT   = 7'b001_0000,
      S_ACK    = 7'b010_0000,
      S_RESULT = 7'b100_0000
   } state_t;

   state_t              state, state_nxt;
   logic [FLAT_W-1:0]   flat;
   logic [6:0]          count;
   logic [31:0]         det;
   logic                rv;

   // Datapath strobes decoded alongside the next state.
   logic                clr_en, wr_en, dec_en, reload_en, cap_en, rv_set, rv_clr;
   logic [7:0]          wr_idx;

   // Bit offset of the slot under the cursor; only used while count < 64.
   assign wr_idx = {count[5:0], 2'b00};

   always_comb begin
      state_nxt = state;
      clr_en    = 1'b0;
      wr_en     = 1'b0;
      dec_en    = 1'b0;
      reload_en = 1'b0;
      cap_en    = 1'b0;
      rv_set    = 1'b0;
      rv_clr    = 1'b0;
      case (state)
         S_CLEAR: begin
            clr_en    = 1'b1;
            state_nxt = S_FILL;
         end
         S_FILL: begin
            if (bus.Clear_Pulse) begin
               state_nxt = S_CLEAR;
            end else if (bus.Enter_Pulse) begin
               // Enter beats a simultaneous Back.
               wr_en = 1'b1;
               if (count == 7'd63) state_nxt = S_READY;
            end else if (bus.Back_Pulse && count != 7'd0) begin
               dec_en = 1'b1;
            end
         end
         S_READY: begin
            if (bus.Clear_Pulse) begin
               state_nxt = S_CLEAR;
            end else if (bus.Go_Pulse) begin
               state_nxt = S_ISSUE;
            end else if (bus.Back_Pulse) begin
               reload_en = 1'b1;
               state_nxt = S_FILL;
            end
         end
         S_ISSUE: begin
            if (bus.Solver_Enter) state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (bus.Solver_Done) begin
               cap_en    = 1'b1;
               state_nxt = S_ACK;
            end
         end
         S_ACK: begin
            rv_set    = 1'b1;
            state_nxt = S_RESULT;
         end
         S_RESULT: begin
            if (bus.Go_Pulse) begin
               rv_clr    = 1'b1;
               state_nxt = S_ISSUE;
            end else if (bus.Back_Pulse) begin
               rv_clr    = 1'b1;
               reload_en = 1'b1;
               state_nxt = S_FILL;
            end else if (bus.Clear_Pulse) begin
               state_nxt = S_CLEAR;
            end
         end
         default: state_nxt = S_CLEAR;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (!Reset) begin
         state <= S_CLEAR;
         flat  <= '0;
         count <= '0;
         det   <= '0;
         rv    <= 1'b0;
      end else begin
         state <= state_nxt;
         if (clr_en) begin
            flat  <= '0;
            count <= '0;
            det   <= '0;
            rv    <= 1'b0;
         end else begin
            // Matrix only changes in FILL, so it is frozen for the solver.
            if (wr_en) begin
               flat[wr_idx +: ENTRY_W] <= bus.Entry_Val;
               count                   <= count + 7'd1;
            end else if (dec_en) begin
               count <= count - 7'd1;
            end else if (reload_en) begin
               count <= 7'd63;
            end
            if (cap_en) det <= bus.Det_In;
            if (rv_set)      rv <= 1'b1;
            else if (rv_clr) rv <= 1'b0;
         end
      end
   end

   assign bus.Matrix_Flat  = flat;
   assign bus.Entry_Count  = count;
   assign bus.Det_Out      = det;
   assign bus.Result_Valid = rv;
   assign bus.Start        = (state == S_ISSUE) & bus.Solver_Enter;
   assign bus.Ack          = (state == S_ACK);
   assign bus.q_Clear      = (state == S_CLEAR);
   assign bus.q_Fill       = (state == S_FILL);
   assign bus.q_Ready      = (state == S_READY);
   assign bus.q_Issue      = (state == S_ISSUE);
   assign bus.q_Wait       = (state == S_WAIT);
   assign bus.q_Ack        = (state == S_ACK);
   assign bus.q_Result     = (state == S_RESULT);
endmodule

// File: tb/tb_matrix_entry_ctrl.sv
// Purpose : self-checking bench for matrix_entry_ctrl against a behavioural model.
// Latency : n/a.
// Backpressure: bench plays the solver and drives Solver_Enter/Solver_Done.
module tb_matrix_entry_ctrl;
   logic clk;
   logic rst;
   matrix_entry_ctrl_if bus ();

   matrix_entry_ctrl dut (
      .Clk   (clk),
      .Reset (rst),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef enum int {M_CLEAR, M_FILL, M_READY, M_ISSUE, M_WAIT, M_ACK, M_RESULT} mst_t;

   mst_t        m_st;
   logic [3:0]  m_ent [64];
   int          m_cnt;
   logic [31:0] m_det;
   bit          m_rv;

   int n_chk = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] model_flat();
      logic [255:0] f;
      f = '0;
      for (int k = 0; k < 64; k++) f[k*4 +: 4] = m_ent[k];
      return f;
   endfunction

   task automatic model_reset();
      m_st = M_CLEAR;
      for (int k = 0; k < 64; k++) m_ent[k] = 4'd0;
      m_cnt = 0;
      m_det = '0;
      m_rv  = 1'b0;
   endtask

   task automatic model_step();
      case (m_st)
         M_CLEAR: begin
            model_reset();
            m_st = M_FILL;
         end
         M_FILL: begin
            if (bus.Clear_Pulse) m_st = M_CLEAR;
            else if (bus.Enter_Pulse) begin
               m_ent[m_cnt] = bus.Entry_Val;
               m_cnt++;
               if (m_cnt == 64) m_st = M_READY;
            end else if (bus.Back_Pulse && m_cnt > 0) m_cnt--;
         end
         M_READY: begin
            if (bus.Clear_Pulse) m_st = M_CLEAR;
            else if (bus.Go_Pulse) m_st = M_ISSUE;
            else if (bus.Back_Pulse) begin m_cnt = 63; m_st = M_FILL; end
         end
         M_ISSUE: if (bus.Solver_Enter) m_st = M_WAIT;
         M_WAIT: if (bus.Solver_Done) begin m_det = bus.Det_In; m_st = M_ACK; end
         M_ACK: begin m_rv = 1'b1; m_st = M_RESULT; end
         M_RESULT: begin
            if (bus.Go_Pulse) begin m_rv = 1'b0; m_st = M_ISSUE; end
            else if (bus.Back_Pulse) begin m_rv = 1'b0; m_cnt = 63; m_st = M_FILL; end
            else if (bus.Clear_Pulse) m_st = M_CLEAR;
         end
         default: m_st = M_CLEAR;
      endcase
   endtask

   task automatic check_all();
      logic [6:0] exp_q;
      exp_q = {m_st == M_RESULT, m_st == M_ACK, m_st == M_WAIT, m_st == M_ISSUE,
               m_st == M_READY, m_st == M_FILL, m_st == M_CLEAR};
      chk("state", {bus.q_Result, bus.q_Ack, bus.q_Wait, bus.q_Issue,
                    bus.q_Ready, bus.q_Fill, bus.q_Clear}, exp_q);
      chk("flat", bus.Matrix_Flat, model_flat());
      chk("count", bus.Entry_Count, m_cnt);
      chk("det", bus.Det_Out, m_det);
      chk("result_valid", bus.Result_Valid, m_rv);
   endtask

   // Called at a negedge with inputs already driven.
   task automatic tick();
      #1;
      chk("start", bus.Start, (m_st == M_ISSUE) && bus.Solver_Enter);
      chk("ack", bus.Ack, m_st == M_ACK);
      @(posedge clk);
      if (!rst) model_reset();
      else model_step();
      @(negedge clk);
      check_all();
   endtask

   task automatic cyc(input bit en, input bit bk, input bit go, input bit cl, input logic [3:0] v);
      bus.Enter_Pulse = en;
      bus.Back_Pulse  = bk;
      bus.Go_Pulse    = go;
      bus.Clear_Pulse = cl;
      bus.Entry_Val   = v;
      tick();
      bus.Enter_Pulse = 1'b0;
      bus.Back_Pulse  = 1'b0;
      bus.Go_Pulse    = 1'b0;
      bus.Clear_Pulse = 1'b0;
   endtask

   logic [255:0] saved_flat;

   initial begin
      rst              = 1'b0;
      bus.Entry_Val    = '0;
      bus.Enter_Pulse  = 1'b0;
      bus.Back_Pulse   = 1'b0;
      bus.Go_Pulse     = 1'b0;
      bus.Clear_Pulse  = 1'b0;
      bus.Solver_Enter = 1'b0;
      bus.Solver_Done  = 1'b0;
      bus.Det_In       = '0;
      model_reset();

      // Reset state
      @(negedge clk);
      @(posedge clk);
      @(negedge clk);
      check_all();
      chk("rst_q_clear", bus.q_Clear, 1'b1);
      tick();
      rst = 1'b1;
      tick();
      chk("rst_to_fill", bus.q_Fill, 1'b1);

      // Entry fill with k mod 16
      for (int k = 0; k < 64; k++) cyc(1, 0, 0, 0, 4'(k % 16));
      chk("fill_slot0", bus.Matrix_Flat[3:0], 4'h0);
      chk("fill_slot15", bus.Matrix_Flat[63:60], 4'hF);
      chk("fill_slot63", bus.Matrix_Flat[255:252], 4'hF);
      chk("fill_count", bus.Entry_Count, 7'd64);
      chk("fill_ready", bus.q_Ready, 1'b1);
      cyc(1, 0, 0, 0, 4'h3);
      chk("ready_enter_ignored", bus.Entry_Count, 7'd64);
      cyc(0, 1, 0, 0, 4'h0);
      chk("ready_back_count", bus.Entry_Count, 7'd63);

      // Correction
      cyc(0, 0, 0, 1, 4'h0);
      tick();
      cyc(1, 0, 0, 0, 4'h5);
      cyc(1, 0, 0, 0, 4'h6);
      cyc(1, 0, 0, 0, 4'h7);
      cyc(0, 1, 0, 0, 4'h0);
      cyc(1, 0, 0, 0, 4'h9);
      chk("corr_slot2", bus.Matrix_Flat[11:8], 4'h9);
      chk("corr_count", bus.Entry_Count, 7'd3);
      cyc(0, 0, 0, 1, 4'h0);
      tick();
      cyc(0, 1, 0, 0, 4'h0);
      chk("back_at_zero", bus.Entry_Count, 7'd0);
      for (int k = 0; k < 3; k++) cyc(1, 0, 0, 0, 4'hA);
      cyc(1, 1, 0, 0, 4'h3);
      chk("enter_back_slot3", bus.Matrix_Flat[15:12], 4'h3);
      chk("enter_back_count", bus.Entry_Count, 7'd4);
      while (m_cnt < 64 && m_st == M_FILL) cyc(1, 0, 0, 0, 4'($urandom_range(0, 15)));

      // Start handshake with delayed Solver_Enter; ignored pulses in ISSUE
      cyc(0, 0, 1, 0, 4'h0);
      chk("go_issue", bus.q_Issue, 1'b1);
      saved_flat = model_flat();
      cyc(1, 0, 0, 0, 4'h1);
      cyc(0, 1, 0, 0, 4'h0);
      cyc(0, 0, 0, 1, 4'h0);
      cyc(0, 0, 0, 0, 4'h0);
      chk("issue_hold_start", bus.Start, 1'b0);
      bus.Solver_Enter = 1'b1;
      #1;
      chk("start_high", bus.Start, 1'b1);
      tick();
      bus.Solver_Enter = 1'b0;
      chk("to_wait", bus.q_Wait, 1'b1);
      chk("start_low_wait", bus.Start, 1'b0);

      // Ignored pulses in WAIT, then result capture
      cyc(1, 0, 0, 0, 4'h2);
      cyc(0, 1, 0, 0, 4'h0);
      cyc(0, 0, 0, 1, 4'h0);
      chk("wait_flat_frozen", bus.Matrix_Flat, saved_flat);
      bus.Det_In      = 32'hFFFF_FFF6;
      bus.Solver_Done = 1'b1;
      tick();
      chk("ack_high", bus.Ack, 1'b1);
      cyc(0, 0, 0, 1, 4'h0);
      chk("ack_low", bus.Ack, 1'b0);
      tick();
      bus.Solver_Done = 1'b0;
      chk("det_capture", bus.Det_Out, 32'hFFFF_FFF6);
      chk("result_valid_set", bus.Result_Valid, 1'b1);

      // Re-issue from RESULT with the same matrix, then reset mid-solve
      cyc(0, 0, 1, 0, 4'h0);
      chk("reissue_flat", bus.Matrix_Flat, saved_flat);
      bus.Solver_Enter = 1'b1;
      tick();
      bus.Solver_Enter = 1'b0;
      tick();
      rst = 1'b0;
      tick();
      rst = 1'b1;
      chk("midrst_q_clear", bus.q_Clear, 1'b1);
      chk("midrst_flat", bus.Matrix_Flat, 256'd0);
      chk("midrst_count", bus.Entry_Count, 7'd0);
      chk("midrst_det", bus.Det_Out, 32'd0);
      chk("midrst_start", bus.Start, 1'b0);
      chk("midrst_ack", bus.Ack, 1'b0);
      tick();

      // Randomized traffic
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 999);
         bus.Solver_Enter = ($urandom_range(0, 3) == 0);
         bus.Solver_Done  = ($urandom_range(0, 4) == 0);
         bus.Det_In       = $urandom;
         rst              = !(r >= 996);
         if (r < 500)      cyc(1, 0, 0, 0, 4'($urandom_range(0, 15)));
         else if (r < 600) cyc(0, 1, 0, 0, 4'($urandom_range(0, 15)));
         else if (r < 630) cyc(1, 1, 0, 0, 4'($urandom_range(0, 15)));
         else if (r < 690) cyc(0, 0, 1, 0, 4'($urandom_range(0, 15)));
         else if (r < 694) cyc(0, 0, 0, 1, 4'($urandom_range(0, 15)));
         else              cyc(0, 0, 0, 0, 4'($urandom_range(0, 15)));
      end
      rst = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end
endmodule
